// File: rtl/cmp_pkg.sv
// Shared types and limits for the serial magnitude comparator.
package cmp_pkg;

    localparam int unsigned CMP_MAX_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } cmp_state_t;

endpackage : cmp_pkg

// File: rtl/bit_cmp_cell.sv
// Single-bit magnitude compare cell.
//   x, y : bits to compare
//   E    : x == y
//   G    : x >  y
//   L    : x <  y
module bit_cmp_cell (
    input  logic x,
    input  logic y,
    output logic E,
    output logic G,
    output logic L
);

    assign E = ~(x ^ y);
    assign G = x & ~y;
    assign L = ~x & y;

endmodule : bit_cmp_cell

// File: rtl/serial_mag_comparator.sv
// Sequential unsigned N-bit magnitude comparator, MSB-first, one bit per clock,
// terminating at the first differing bit.
//   clk, rst_n : clock, async active-low reset
//   start      : compare request, accepted only while idle
//   a, b       : operands, captured on the accepting edge
//   busy       : scan in progress
//   done       : one-cycle result-valid pulse
//   eq, gt, lt : one-hot result, held until the next accepted start
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    // Elaboration-time range check on the operand width.
    if (WIDTH < 2 || WIDTH > CMP_MAX_WIDTH) begin : g_width_check
        $error("serial_mag_comparator: WIDTH out of range 2..%0d", CMP_MAX_WIDTH);
    end

    cmp_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic cell_e, cell_g, cell_l;

    // Compare cell sees the bit currently under the scan index.
    bit_cmp_cell u_cell (
        .x (ra_q[idx_q]),
        .y (rb_q[idx_q]),
        .E (cell_e),
        .G (cell_g),
        .L (cell_l)
    );

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    idx_d   = IDX_W'(WIDTH - 1);
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cell_g) begin
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cell_l) begin
                    lt_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (cell_e && (idx_q == '0)) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign eq   = eq_q;
    assign gt   = gt_q;
    assign lt   = lt_q;

endmodule : serial_mag_comparator
